// File: rtl/demux5_deserializer.sv
// demux5_deserializer: receiving end of the 5:1 mux path.
// Accepts one bit per handshake, steers it into a lane of an assembly
// register (scan-counter or sender-addressed), and hands each completed
// word to a single-entry valid/ready output slot.
module demux5_deserializer #(
    parameter int N     = 5,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic [SEL_W-1:0] s,
    input  logic             addr_mode,
    output logic             in_ready,
    output logic [N-1:0]     y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             sel_err
);

    typedef enum logic {
        ASSEMBLE = 1'b0,
        FULL     = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(N - 1);

    state_t           state_q, state_d;
    logic [N-1:0]     lane_q, lane_d;
    logic [N-1:0]     filled_q, filled_d;
    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    // Cleared by reset; until the first edge after release the mode is taken
    // straight from addr_mode, so mode_q latches the release-time mode
    // without an asynchronous load of a data input.
    logic             init_q, init_d;
    logic [N-1:0]     y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic             sel_err_q, sel_err_d;

    // One-hot lane decodes for the scan counter and the addressed select.
    // An out-of-range select decodes to all zeros, which is how it is detected.
    logic [N-1:0] scan_hit;
    logic [N-1:0] addr_hit;

    for (genvar gi = 0; gi < N; gi++) begin : g_lane_dec
        assign scan_hit[gi] = (cnt_q == SEL_W'(gi));
        assign addr_hit[gi] = (s == SEL_W'(gi));
    end

    logic accept;
    logic consume;
    logic mode_eff;
    logic mode_chg;
    logic s_ok;
    logic complete;

    // Next-state logic: lane steering, frame completion and output-slot handoff.
    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        filled_d  = filled_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        init_d    = 1'b1;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        sel_err_d = 1'b0;
        complete  = 1'b0;

        accept   = in_valid && (state_q == ASSEMBLE);
        consume  = y_valid_q && y_ready;
        mode_eff = init_q ? mode_q : addr_mode;
        mode_chg = init_q && (addr_mode != mode_q);
        s_ok     = |addr_hit;

        if (!init_q) begin
            mode_d = addr_mode;
        end

        case (state_q)
            ASSEMBLE: begin
                if (mode_chg) begin
                    // A mode switch throws away the partial frame and the
                    // bit offered this cycle.
                    mode_d   = addr_mode;
                    cnt_d    = '0;
                    filled_d = '0;
                end else if (accept) begin
                    if (!mode_eff) begin
                        lane_d = (lane_q & ~scan_hit) | (scan_hit & {N{in_bit}});
                        if (cnt_q == LAST_LANE) begin
                            complete = 1'b1;
                        end else begin
                            cnt_d = cnt_q + SEL_W'(1);
                        end
                    end else if (s_ok) begin
                        lane_d   = (lane_q & ~addr_hit) | (addr_hit & {N{in_bit}});
                        filled_d = filled_q | addr_hit;
                        complete = &filled_d;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end

                if (complete) begin
                    cnt_d    = '0;
                    filled_d = '0;
                    if (!y_valid_q || consume) begin
                        y_d       = lane_d;
                        y_valid_d = 1'b1;
                    end else begin
                        // Slot occupied: the finished word waits in lane_q.
                        state_d = FULL;
                    end
                end else if (consume) begin
                    y_valid_d = 1'b0;
                end
            end
            FULL: begin
                if (consume) begin
                    y_d     = lane_q;
                    state_d = ASSEMBLE;
                end
            end
            default: begin
                state_d = ASSEMBLE;
            end
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ASSEMBLE;
            lane_q    <= '0;
            filled_q  <= '0;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            init_q    <= 1'b0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            filled_q  <= filled_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            init_q    <= init_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign in_ready = (state_q == ASSEMBLE);
    assign y        = y_q;
    assign y_valid  = y_valid_q;
    assign sel_err  = sel_err_q;

endmodule

// File: tb/tb_demux5_deserializer.sv
// Self-checking bench for demux5_deserializer: a directed vector table, a few
// multi-cycle sequences, and a randomized run, all watched by a scoreboard.
`timescale 1ns/1ps
module tb_demux5_deserializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic [2:0] s = '0;
    logic       addr_mode = 1'b0;
    logic       in_ready;
    logic [4:0] y;
    logic       y_valid;
    logic       y_ready = 1'b1;
    logic       sel_err;

    int checks = 0;
    int failures = 0;

    demux5_deserializer #(.N(5), .SEL_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .s         (s),
        .addr_mode (addr_mode),
        .in_ready  (in_ready),
        .y         (y),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    // Queue holds completed words not yet consumed, front = word in the slot.
    logic [4:0] exp_q[$];
    logic [4:0] lane_m = '0;
    logic [4:0] filled_m = '0;
    int         cnt_m = 0;
    logic       mode_m = 1'b0;
    logic       started = 1'b0;
    logic       perr_m = 1'b0;
    int         frames_done = 0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            cnt_m    = 0;
            filled_m = '0;
            started  = 1'b0;
            perr_m   = 1'b0;
        end else begin
            logic rdy_m;
            logic consume_m;
            logic complete_m;
            logic perr_next;
            check("mon_y_valid", {31'b0, y_valid}, {31'b0, exp_q.size() != 0});
            check("mon_in_ready", {31'b0, in_ready}, {31'b0, exp_q.size() < 2});
            check("mon_sel_err", {31'b0, sel_err}, {31'b0, perr_m});
            if (exp_q.size() != 0) check("mon_y", {27'b0, y}, {27'b0, exp_q[0]});

            rdy_m      = (exp_q.size() < 2);
            consume_m  = (exp_q.size() != 0) && y_ready;
            complete_m = 1'b0;
            perr_next  = 1'b0;
            if (rdy_m) begin
                if (started && addr_mode != mode_m) begin
                    cnt_m    = 0;
                    filled_m = '0;
                    mode_m   = addr_mode;
                end else begin
                    if (!started) mode_m = addr_mode;
                    if (in_valid) begin
                        if (!mode_m) begin
                            lane_m[cnt_m] = in_bit;
                            if (cnt_m == 4) begin
                                cnt_m = 0;
                                complete_m = 1'b1;
                            end else begin
                                cnt_m++;
                            end
                        end else if (s < 3'd5) begin
                            lane_m[s]   = in_bit;
                            filled_m[s] = 1'b1;
                            if (filled_m == 5'h1f) begin
                                filled_m   = '0;
                                complete_m = 1'b1;
                            end
                        end else begin
                            perr_next = 1'b1;
                        end
                    end
                end
            end
            started = 1'b1;
            perr_m  = perr_next;
            if (consume_m) void'(exp_q.pop_front());
            if (complete_m) begin
                exp_q.push_back(lane_m);
                frames_done++;
            end
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       mode;
        logic       vld;
        logic [2:0] sel;
        logic       b;
        logic       yrdy;
        logic [4:0] ey;
        logic       ev;
        logic       eerr;
        logic       erdy;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic m, input logic v, input logic [2:0] sl, input logic b,
                                input logic yr, input logic [4:0] ey, input logic ev,
                                input logic ee, input logic er);
        vec_t r;
        r.mode = m; r.vld = v; r.sel = sl; r.b = b; r.yrdy = yr;
        r.ey = ey; r.ev = ev; r.eerr = ee; r.erdy = er;
        return r;
    endfunction

    task automatic step(input logic m, input logic v, input logic [2:0] sl, input logic b, input logic yr);
        addr_mode = m; in_valid = v; s = sl; in_bit = b; y_ready = yr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // scan frame 1,0,1,1,0 -> 5'b01101
        tbl[0]  = mk(0, 1, 0, 1, 1, 5'h00, 0, 0, 1);
        tbl[1]  = mk(0, 1, 0, 0, 1, 5'h00, 0, 0, 1);
        tbl[2]  = mk(0, 1, 0, 1, 1, 5'h00, 0, 0, 1);
        tbl[3]  = mk(0, 1, 0, 1, 1, 5'h00, 0, 0, 1);
        tbl[4]  = mk(0, 1, 0, 0, 1, 5'h0D, 1, 0, 1);
        // switch to addressed mode (idle), word consumed
        tbl[5]  = mk(1, 0, 0, 0, 1, 5'h0D, 0, 0, 1);
        // (4,1),(0,1),(2,0),(1,0),(3,1) -> 5'b11001
        tbl[6]  = mk(1, 1, 4, 1, 1, 5'h0D, 0, 0, 1);
        tbl[7]  = mk(1, 1, 0, 1, 1, 5'h0D, 0, 0, 1);
        tbl[8]  = mk(1, 1, 2, 0, 1, 5'h0D, 0, 0, 1);
        tbl[9]  = mk(1, 1, 1, 0, 1, 5'h0D, 0, 0, 1);
        tbl[10] = mk(1, 1, 3, 1, 1, 5'h19, 1, 0, 1);
        // rewrite lane 2 twice: no frame
        tbl[11] = mk(1, 1, 2, 1, 1, 5'h19, 0, 0, 1);
        tbl[12] = mk(1, 1, 2, 0, 1, 5'h19, 0, 0, 1);
        // bad selects 5 and 7
        tbl[13] = mk(1, 1, 5, 1, 1, 5'h19, 0, 1, 1);
        tbl[14] = mk(1, 0, 0, 0, 1, 5'h19, 0, 0, 1);
        tbl[15] = mk(1, 1, 7, 0, 1, 5'h19, 0, 1, 1);
        tbl[16] = mk(1, 0, 0, 0, 1, 5'h19, 0, 0, 1);
        // lane 2 (=0) already filled: 4 more bits complete 5'b10011
        tbl[17] = mk(1, 1, 0, 1, 1, 5'h19, 0, 0, 1);
        tbl[18] = mk(1, 1, 1, 1, 1, 5'h19, 0, 0, 1);
        tbl[19] = mk(1, 1, 3, 0, 1, 5'h19, 0, 0, 1);
        tbl[20] = mk(1, 1, 4, 1, 1, 5'h13, 1, 0, 1);
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [4:0] w;
        int target;
        int cyc;

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_y", {27'b0, y}, 32'h0);
        check("reset_y_valid", {31'b0, y_valid}, 32'h0);
        check("reset_in_ready", {31'b0, in_ready}, 32'h1);
        check("reset_sel_err", {31'b0, sel_err}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].mode, tbl[i].vld, tbl[i].sel, tbl[i].b, tbl[i].yrdy);
            check($sformatf("row%0d_y", i), {27'b0, y}, {27'b0, tbl[i].ey});
            check($sformatf("row%0d_y_valid", i), {31'b0, y_valid}, {31'b0, tbl[i].ev});
            check($sformatf("row%0d_sel_err", i), {31'b0, sel_err}, {31'b0, tbl[i].eerr});
            check($sformatf("row%0d_in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].erdy});
        end

        // Backpressure: two scan frames 5'h15 then 5'h0A with y_ready low.
        step(0, 0, 0, 0, 1);
        check("bp_start_empty", {31'b0, y_valid}, 32'h0);
        w = 5'h15;
        for (int i = 0; i < 5; i++) step(0, 1, 0, w[i], 0);
        w = 5'h0A;
        for (int i = 0; i < 5; i++) step(0, 1, 0, w[i], 0);
        check("bp_held_y", {27'b0, y}, 32'h15);
        check("bp_held_valid", {31'b0, y_valid}, 32'h1);
        check("bp_full_in_ready", {31'b0, in_ready}, 32'h0);
        step(0, 0, 0, 0, 1);
        check("bp_release_y", {27'b0, y}, 32'h0A);
        check("bp_release_valid", {31'b0, y_valid}, 32'h1);
        check("bp_release_in_ready", {31'b0, in_ready}, 32'h1);

        // Mode switch mid-frame: 3 scan bits, then addressed frame 5'b00110.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1'b1, 1);
        step(1, 1, 4, 1, 1);
        step(1, 1, 0, 0, 1);
        step(1, 1, 1, 1, 1);
        step(1, 1, 2, 1, 1);
        step(1, 1, 3, 0, 1);
        check("msw_no_early_frame", {31'b0, y_valid}, 32'h0);
        step(1, 1, 4, 0, 1);
        check("msw_y", {27'b0, y}, 32'h06);
        check("msw_valid", {31'b0, y_valid}, 32'h1);

        // Reset mid-frame with an occupied slot.
        step(1, 1, 0, 1, 0);
        step(1, 1, 1, 0, 0);
        step(1, 1, 2, 1, 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #0.5;
        check("mid_rst_y", {27'b0, y}, 32'h0);
        check("mid_rst_valid", {31'b0, y_valid}, 32'h0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'h1);
        check("mid_rst_sel_err", {31'b0, sel_err}, 32'h0);
        #0.5 rst_n = 1'b1;
        step(1, 1, 3, 1, 1);
        step(1, 1, 4, 1, 1);
        check("post_rst_partial_gone", {31'b0, y_valid}, 32'h0);
        step(1, 1, 0, 1, 1);
        step(1, 1, 1, 1, 1);
        step(1, 1, 2, 1, 1);
        check("post_rst_y", {27'b0, y}, 32'h1F);

        // Random traffic, alternating modes, 4 x 256 frames.
        for (int ph = 0; ph < 4; ph++) begin
            target = frames_done + 256;
            cyc = 0;
            while (frames_done < target && cyc < 20000) begin
                step(ph[0], $urandom_range(0, 3) != 0, 3'($urandom_range(0, 5)),
                     1'($urandom), $urandom_range(0, 2) != 0);
                cyc++;
            end
            check($sformatf("random_phase%0d_progress", ph), {31'b0, frames_done >= target}, 32'h1);
        end

        // Drain the slot.
        for (int i = 0; i < 3; i++) step(addr_mode, 0, 0, 0, 1);
        check("drain_empty", {31'b0, y_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux5_deserializer.md
# demux5_deserializer

Receiving end of the 5:1 mux path: takes one bit per accepted transfer, steers it to lane `s` of a 5-lane assembly register (demultiplex), and, once all lanes are written, presents the reassembled word `y[4:0]` through a valid/ready output slot. It supports two modes. In scan mode, an internal select counter walks lanes 0..4, matching a counter-driven mux5 sender. In addressed mode, the sender supplies the select with each bit. It sits downstream of the shifter/mux datapath and is the parallel-reconstruction counterpart of `mux5`.

## Interface
- `N`, default 5: number of lanes, valid range 2..8.
- `SEL_W`, default 3: select width. Must satisfy `SEL_W >= $clog2(N)`.
- `clk`  in  1: single clock. All state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `in_valid`  in  1: `in_bit` (and `s` in addressed mode) is valid.
- `in_bit`  in  1: serial data bit.
- `s`  in  SEL_W: target lane. Used only when `addr_mode` is 1.
- `addr_mode`  in  1: 0 selects scan mode, 1 selects addressed mode.
- `in_ready`  out  1: block can accept a bit this cycle.
- `y`  out  N: reassembled word. Bit `i` is the lane-`i` bit.
- `y_valid`  out  1: `y` holds an unconsumed frame.
- `y_ready`  in  1: consumer takes `y` when `y_valid` and `y_ready` are both 1.
- `sel_err`  out  1: one-cycle pulse, accepted addressed bit had `s >= N`.

## Operation
- **Accept:** a bit is accepted on a rising edge when `in_valid` and `in_ready` are both 1.
- **Registered state:**
  - lane register `lane[N-1:0]`
  - fill mask `filled[N-1:0]`
  - scan counter `cnt` (SEL_W bits)
  - registered mode `mode_q`
  - FSM state `ASSEMBLE` or `FULL`
  - output slot `y`, `y_valid`
- **Scan mode:**
  - Accepted bit writes `lane[cnt]`.
  - `cnt` increments; after lane N-1 it wraps to 0 and the frame is complete.
  - `s` is ignored.
- **Addressed mode:**
  - Accepted bit with `s < N` writes `lane[s]` and sets `filled[s]`.
  - Frame completes on the accept that makes `filled` all ones.
  - Rewriting an already-filled lane overwrites it (last write wins) and does not complete the frame.
  - Accepted bit with `s >= N` is dropped: no lane or mask change, `sel_err` = 1 the next cycle only.
- **Frame completion:**
  - The completed frame moves into the output slot on the same edge if the slot is free: `y_valid` = 0, or `y_valid && y_ready` this cycle.
  - Otherwise the FSM goes to `FULL`.
  - In either case `cnt` and `filled` clear to 0.
- **FULL state:**
  - `in_ready` = 0.
  - On an edge with `y_valid && y_ready`, the completed frame loads into `y`, `y_valid` stays 1, and the FSM returns to `ASSEMBLE`.
- **Output consume:** `y_valid && y_ready` with no frame transferring that edge gives `y_valid` = 0. `y` holds its last value.
- **Mode change:** `addr_mode` != `mode_q` in `ASSEMBLE`:
  - discards the partial frame (`cnt` = 0, `filled` = 0) and any accept that cycle;
  - `mode_q` updates on that edge.
  - In `FULL`, the mode change is deferred until the FSM returns to `ASSEMBLE`.
- **Reset values:** `y` = 0, `y_valid` = 0, `sel_err` = 0, `in_ready` = 1, `cnt` = 0, `filled` = 0, `lane` = 0, state `ASSEMBLE`, `mode_q` = `addr_mode` at release.
- **Reset mid-frame:** asserting `rst_n` low mid-frame discards the partial frame and the output slot immediately.

## Timing
- `in_ready` is a function of FSM state only. There is no combinational path from `in_valid` or `y_ready`.
- Latency: the last bit accepted at edge k gives `y_valid` = 1 with the new `y` after edge k, when the slot is free.
- Throughput: one bit per cycle. With `y_ready` held at 1, `in_ready` never drops.
- Simultaneous consume and completion at the same edge: the new frame replaces the old one and `y_valid` stays 1. No bubble and no loss.
- `sel_err` is registered: high exactly one cycle, the cycle after the offending accept.

## Test plan
- **Scan, free-running:** `addr_mode` = 0, `y_ready` = 1, bits 1,0,1,1,0 on consecutive cycles -> one cycle after the 5th accept, `y` = 5'b01101 and `y_valid` = 1; `in_ready` stays 1.
- **Addressed, out of order:** send (s,bit) = (4,1),(0,1),(2,0),(1,0),(3,1) -> `y` = 5'b11001 after the 5th accept. Then send (2,1),(2,0) -> no new frame (only lane 2 filled).
- **Bad select:** addressed, s = 5, then s = 7 -> `sel_err` pulses one cycle each; `filled` unchanged; the next valid frame is assembled correctly.
- **Backpressure:** `y_ready` = 0, two scan frames 5'h15 then 5'h0A ->
  - `y` = 5'h15 is held and `in_ready` = 0 after the 10th accept;
  - raising `y_ready` for 1 cycle gives `y` = 5'h0A, `y_valid` = 1, `in_ready` = 1;
  - random `in_valid`/`y_ready` over 1024 frames against a reference model: zero mismatches.
- **Mode switch mid-frame:** 3 scan bits, then `addr_mode` = 1 -> partial frame dropped, no `y_valid`; the following addressed frame completes normally.
- **Reset mid-frame:** `rst_n` low for 1 ns with 3 bits accepted and `y_valid` = 1 -> all outputs return to reset values immediately, without a clock edge.
